// File: rtl/prm_sched_pkg.sv
// Shared types and constants for the PRM edge-check scheduler: FSM state,
// edge code width and the checker input letter-to-bit map.
package prm_sched_pkg;

  localparam int unsigned CODE_W = 15;

  localparam int unsigned CHK_A = 0;
  localparam int unsigned CHK_B = 1;
  localparam int unsigned CHK_C = 2;
  localparam int unsigned CHK_D = 3;
  localparam int unsigned CHK_E = 4;
  localparam int unsigned CHK_F = 5;
  localparam int unsigned CHK_G = 6;
  localparam int unsigned CHK_H = 7;
  localparam int unsigned CHK_I = 8;
  localparam int unsigned CHK_J = 9;
  localparam int unsigned CHK_K = 10;
  localparam int unsigned CHK_L = 11;
  localparam int unsigned CHK_M = 12;
  localparam int unsigned CHK_N = 13;
  localparam int unsigned CHK_O = 14;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    CHECK,
    WRITE,
    FIN
  } sched_state_e;

endpackage

// File: rtl/prm_mask_reduce.sv
// OR-reduces the checker bank edge_mask vector to a single blocked flag,
// with an optional register stage for large banks.
module prm_mask_reduce #(
  parameter int unsigned NUM_CHK   = 8,
  parameter bit          REG_STAGE = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CHK-1:0] mask,
  output logic               any_set
);

  logic any_c;

  assign any_c = |mask;

  generate
    if (REG_STAGE) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          any_set <= 1'b0;
        end else begin
          any_set <= any_c;
        end
      end
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign any_set = any_c;
    end
  endgenerate

endmodule

// File: rtl/prm_edge_check_sched.sv
// Sweeps a list of roadmap edges through the obstacle checker bank, writing
// one blocked/free bit per edge and counting blocked edges.
module prm_edge_check_sched #(
  parameter int unsigned EDGE_AW = 10,
  parameter int unsigned NUM_CHK = 8,
  parameter int unsigned CODE_W  = prm_sched_pkg::CODE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [EDGE_AW:0]   edge_cnt,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [EDGE_AW:0]   blocked_cnt,
  output logic               em_rd,
  output logic [EDGE_AW-1:0] em_addr,
  input  logic [CODE_W-1:0]  em_data,
  output logic [CODE_W-1:0]  chk_code,
  input  logic [NUM_CHK-1:0] chk_mask,
  output logic               res_we,
  output logic [EDGE_AW-1:0] res_addr,
  output logic               res_data
);
  import prm_sched_pkg::*;

  sched_state_e       state;
  logic [EDGE_AW-1:0] idx;
  logic [EDGE_AW:0]   cnt_q;
  logic               any_blocked;
  logic               last_edge;
  logic               in_sweep;

  prm_mask_reduce #(
    .NUM_CHK   (NUM_CHK),
    .REG_STAGE (1'b0)
  ) u_mask_reduce (
    .clk     (clk),
    .rst_n   (rst_n),
    .mask    (chk_mask),
    .any_set (any_blocked)
  );

  // Compared at full width so a count of 2^EDGE_AW ends at index all-ones.
  assign last_edge = ({1'b0, idx} == (cnt_q - (EDGE_AW+1)'(1)));
  assign in_sweep  = (state == FETCH) || (state == WAIT) ||
                     (state == CHECK) || (state == WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      blocked_cnt <= '0;
      em_rd       <= 1'b0;
      em_addr     <= '0;
      chk_code    <= '0;
      res_we      <= 1'b0;
      res_addr    <= '0;
      res_data    <= 1'b0;
    end else begin
      em_rd  <= 1'b0;
      res_we <= 1'b0;
      if (abort && in_sweep) begin
        state   <= FIN;
        done    <= 1'b1;
        aborted <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              cnt_q       <= edge_cnt;
              idx         <= '0;
              blocked_cnt <= '0;
              aborted     <= 1'b0;
              busy        <= 1'b1;
              if (edge_cnt == '0) begin
                state <= FIN;
              end else begin
                state   <= FETCH;
                em_rd   <= 1'b1;
                em_addr <= '0;
              end
            end
          end
          FETCH: state <= WAIT;
          WAIT: begin
            chk_code <= em_data;
            state    <= CHECK;
          end
          CHECK: state <= WRITE;
          WRITE: begin
            res_we   <= 1'b1;
            res_addr <= idx;
            res_data <= any_blocked;
            if (any_blocked && (blocked_cnt != '1)) begin
              blocked_cnt <= blocked_cnt + (EDGE_AW+1)'(1);
            end
            if (last_edge) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              idx     <= idx + EDGE_AW'(1);
              em_rd   <= 1'b1;
              em_addr <= idx + EDGE_AW'(1);
              state   <= FETCH;
            end
          end
          FIN: begin
            // An empty sweep enters FIN with done low and raises it here, one
            // cycle later than a sweep that ran edges.
            if (done) begin
              done  <= 1'b0;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              done <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prm_edge_check_sched.sv
// Directed and randomized sweeps of prm_edge_check_sched against a
// behavioural model of edge memory, checker bank and sweep timing.
module tb_prm_edge_check_sched;

  localparam int unsigned EDGE_AW = 10;
  localparam int unsigned NUM_CHK = 8;
  localparam int unsigned CODE_W  = 15;
  localparam int unsigned N_EDGES = 1 << EDGE_AW;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [EDGE_AW:0]   edge_cnt = '0;
  logic               busy;
  logic               done;
  logic               aborted;
  logic [EDGE_AW:0]   blocked_cnt;
  logic               em_rd;
  logic [EDGE_AW-1:0] em_addr;
  logic [CODE_W-1:0]  em_data = '0;
  logic [CODE_W-1:0]  chk_code;
  logic [NUM_CHK-1:0] chk_mask;
  logic               res_we;
  logic [EDGE_AW-1:0] res_addr;
  logic               res_data;

  logic [CODE_W-1:0] mem [N_EDGES];
  logic [CODE_W-1:0] obst [NUM_CHK];
  int mode = 0;   // 0: only code 0x4000 blocked, 1: random obstacles, 2: all blocked
  int checks = 0;
  int failures = 0;

  prm_edge_check_sched #(
    .EDGE_AW (EDGE_AW),
    .NUM_CHK (NUM_CHK),
    .CODE_W  (CODE_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .edge_cnt    (edge_cnt),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .blocked_cnt (blocked_cnt),
    .em_rd       (em_rd),
    .em_addr     (em_addr),
    .em_data     (em_data),
    .chk_code    (chk_code),
    .chk_mask    (chk_mask),
    .res_we      (res_we),
    .res_addr    (res_addr),
    .res_data    (res_data)
  );

  always #5 clk = ~clk;

  // Edge memory: data valid one cycle after the read strobe.
  always @(posedge clk) if (em_rd) em_data <= mem[em_addr];

  // Checker bank model.
  always_comb begin
    chk_mask = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
      case (mode)
        0:       chk_mask[i] = (i == 3) && (chk_code == 15'h4000);
        1:       chk_mask[i] = ((chk_code & obst[i]) != '0);
        default: chk_mask[i] = 1'b1;
      endcase
    end
  end

  function automatic logic exp_blocked(input logic [CODE_W-1:0] code);
    if (mode == 0) return code == 15'h4000;
    if (mode == 1) begin
      for (int i = 0; i < NUM_CHK; i++) if ((code & obst[i]) != '0) return 1'b1;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sweep of n edges; edge i occupies cycles 4i+1..4i+4 after the start
  // cycle 0, its write is visible in cycle 4i+5. Negative *_at means unused.
  task automatic sweep(input string tag, input int n, input int abort_at,
                       input int restart_at, input int rst_at);
    int exp_wr, exp_fetch, exp_dcount, exp_dcyc, budget, dcount, dcyc, exp_blk;
    logic dab, busy1;
    int wr_addr[$];
    logic wr_data[$];
    int rd_addr[$];

    exp_wr = 0; exp_fetch = 0; exp_blk = 0;
    for (int i = 0; i < n; i++) begin
      if (rst_at >= 0) begin
        if (4*i + 5 <= rst_at) exp_wr++;
        if (4*i + 1 <= rst_at) exp_fetch++;
      end else if (abort_at >= 0) begin
        if (4*i + 4 < abort_at) exp_wr++;
        if (4*i + 1 <= abort_at) exp_fetch++;
      end else begin
        exp_wr++;
        exp_fetch++;
      end
    end
    exp_dcount = (rst_at >= 0) ? 0 : 1;
    exp_dcyc   = (abort_at >= 0) ? abort_at + 1 : ((n == 0) ? 2 : 4*n + 1);
    budget     = (rst_at >= 0) ? rst_at + 8 : 4*n + 12;

    dcount = 0; dcyc = 0; dab = 1'b0; busy1 = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    edge_cnt = (EDGE_AW+1)'(n);
    for (int k = 0; k <= budget; k++) begin
      @(negedge clk);
      if (res_we) begin
        wr_addr.push_back(int'(res_addr));
        wr_data.push_back(res_data);
      end
      if (em_rd) rd_addr.push_back(int'(em_addr));
      if (done) begin
        dcount++;
        dcyc = k;
        dab = aborted;
      end
      if (k == 1) busy1 = busy;
      start = (k == 0) || (k == restart_at);
      if (k == restart_at) edge_cnt = edge_cnt + (EDGE_AW+1)'(3);
      abort = (k == abort_at);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check({tag, "/rst_flags"}, 32'({busy, done, aborted, em_rd, res_we, res_data}), 32'd0);
        check({tag, "/rst_blocked"}, 32'(blocked_cnt), 32'd0);
        check({tag, "/rst_addrs"}, 32'({em_addr, res_addr}), 32'd0);
        check({tag, "/rst_code"}, 32'(chk_code), 32'd0);
      end
      if ((rst_at >= 0) && (k == rst_at + 2)) rst_n = 1'b1;
      if ((dcount > 0) && (k >= dcyc + 4)) break;
    end
    abort = 1'b0;
    start = 1'b0;

    check({tag, "/done_count"}, 32'(dcount), 32'(exp_dcount));
    if ((exp_dcount == 1) && (dcount >= 1)) begin
      check({tag, "/done_cycle"}, 32'(dcyc), 32'(exp_dcyc));
      check({tag, "/aborted"}, 32'(dab), 32'(abort_at >= 0));
    end
    if (n > 0) check({tag, "/busy_early"}, 32'(busy1), 32'd1);
    check({tag, "/writes"}, 32'(wr_addr.size()), 32'(exp_wr));
    for (int i = 0; i < exp_wr && i < wr_addr.size(); i++) begin
      check($sformatf("%s/wr_addr%0d", tag, i), 32'(wr_addr[i]), 32'(i));
      check($sformatf("%s/wr_data%0d", tag, i), 32'(wr_data[i]), 32'(exp_blocked(mem[i])));
      if (exp_blocked(mem[i])) exp_blk++;
    end
    check({tag, "/fetches"}, 32'(rd_addr.size()), 32'(exp_fetch));
    for (int i = 0; i < exp_fetch && i < rd_addr.size(); i++)
      check($sformatf("%s/rd_addr%0d", tag, i), 32'(rd_addr[i]), 32'(i));
    check({tag, "/blocked_cnt"}, 32'(blocked_cnt), (rst_at >= 0) ? 32'd0 : 32'(exp_blk));
    check({tag, "/busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    for (int i = 0; i < N_EDGES; i++) mem[i] = '0;
    for (int i = 0; i < NUM_CHK; i++) obst[i] = '0;

    repeat (3) @(negedge clk);
    check("reset/flags", 32'({busy, done, aborted, em_rd, res_we, res_data}), 32'd0);
    check("reset/blocked", 32'(blocked_cnt), 32'd0);
    check("reset/addrs", 32'({em_addr, res_addr}), 32'd0);
    check("reset/code", 32'(chk_code), 32'd0);
    rst_n = 1'b1;

    mode = 0;
    mem[0] = 15'h0001; mem[1] = 15'h4000; mem[2] = 15'h7FFF;
    sweep("basic", 3, -1, -1, -1);
    repeat (3) @(negedge clk);
    check("basic/code_hold", 32'(chk_code), 32'h7FFF);

    sweep("zero", 0, -1, -1, -1);

    mode = 2;
    for (int i = 0; i < 5; i++) mem[i] = CODE_W'($urandom);
    sweep("abort", 5, 8, -1, -1);

    mode = 1;
    for (int i = 0; i < NUM_CHK; i++) obst[i] = CODE_W'(1 << $urandom_range(14, 0));
    sweep("restart", 4, -1, 6, -1);

    mode = 2;
    sweep("reset", 5, -1, -1, 11);
    mode = 0;
    mem[3] = 15'h4000;
    sweep("after_reset", 5, -1, -1, -1);

    mode = 1;
    for (int s = 0; s < 6; s++) begin
      int n;
      int ab;
      n = int'($urandom_range(16, 1));
      for (int i = 0; i < NUM_CHK; i++)
        obst[i] = ($urandom_range(2, 0) == 0) ? '0 : CODE_W'(1 << $urandom_range(14, 0));
      for (int i = 0; i < n; i++)
        mem[i] = CODE_W'((1 << $urandom_range(14, 0)) | (1 << $urandom_range(14, 0)));
      ab = ((s % 2) == 1) ? int'($urandom_range(4*n, 1)) : -1;
      sweep($sformatf("rand%0d", s), n, ab, -1, -1);
    end

    mode = 2;
    for (int i = 0; i < N_EDGES; i++) mem[i] = CODE_W'($urandom);
    sweep("full", N_EDGES, -1, -1, -1);
    check("full/last_addr", 32'(res_addr), 32'(N_EDGES - 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
